// File: rtl/multicore_controller_if.sv
// ---------------------------------------------------------------------------
// multicore_controller_if
//   Memory handshake bundle between the multicore controller and the
//   instruction/data memory.
//
//   Signals:
//     mem_rd  : read strobe, held until the memory acknowledges
//     mem_wr  : write strobe, held until the memory acknowledges
//     mem_ack : memory completes the current read or write
//
//   Modports:
//     master  : controller side (drives strobes, receives ack)
//     slave   : memory side (receives strobes, drives ack)
// ---------------------------------------------------------------------------
interface multicore_controller_if;
    logic mem_rd;
    logic mem_wr;
    logic mem_ack;

    modport master (
        output mem_rd,
        output mem_wr,
        input  mem_ack
    );

    modport slave (
        input  mem_rd,
        input  mem_wr,
        output mem_ack
    );
endinterface

// File: rtl/multicore_controller.sv
// ---------------------------------------------------------------------------
// multicore_controller
//   Fetch/decode/execute sequencer for a lockstep array of NCORES matrix
//   datapath cores. Drives named control strobes, handshakes with memory
//   through multicore_controller_if, and supports a multi-cycle multiply.
//
//   Parameters:
//     IR_W     : instruction register width
//     OPCODE_W : opcode field width, IR[IR_W-1 -: OPCODE_W]
//     NCORES   : number of lockstep cores (>= 1)
//     MUL_LAT  : multiply latency in cycles (>= 1)
//
//   Ports:
//     clk, rst_n          : clock (rising edge), async active-low reset
//     start               : begin program (accepted in IDLE or HALT)
//     IR                  : instruction from the datapath IR register
//     z                   : per-core accumulator-zero flags
//     core_mask           : per-core participation mask (CORE_MASK_EN only)
//     mem                 : memory handshake (mem_rd, mem_wr, mem_ack)
//     pc_clr/inc/load     : program counter controls
//     ir_load             : latch memory data into IR
//     ar_load, ar_inc     : address register controls
//     alu_op              : 000 pass, 001 add, 010 mul
//     acc_load            : write ALU result to accumulators
//     core_en             : per-core enable
//     busy, done, illegal : status
//
//   Build option:
//     CORE_MASK_EN : when defined, adds core_mask, captured on an accepted
//                    start; it gates core_en and the JMPNZ zero reduction.
//                    When undefined, all cores always participate.
//
//   All outputs are decoded from the state register, the registered opcode
//   and the multiply counter; the only combinational input path is z ->
//   pc_load during a JMPNZ execute cycle.
// ---------------------------------------------------------------------------
module multicore_controller #(
    parameter int IR_W     = 16,
    parameter int OPCODE_W = 4,
    parameter int NCORES   = 4,
    parameter int MUL_LAT  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [IR_W-1:0]          IR,
    input  logic [NCORES-1:0]        z,
`ifdef CORE_MASK_EN
    input  logic [NCORES-1:0]        core_mask,
`endif
    multicore_controller_if.master   mem,
    output logic                     pc_clr,
    output logic                     pc_inc,
    output logic                     pc_load,
    output logic                     ir_load,
    output logic                     ar_load,
    output logic                     ar_inc,
    output logic [2:0]               alu_op,
    output logic                     acc_load,
    output logic [NCORES-1:0]        core_en,
    output logic                     busy,
    output logic                     done,
    output logic                     illegal
);

    // Counter must be able to hold MUL_LAT; it counts 0 .. MUL_LAT-1.
    localparam int MUL_CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
    localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_LAT - 1);

    // Opcode values (compared after zero-extension to 32 bits so that a
    // narrow OPCODE_W never truncates the constants).
    localparam logic [31:0] OP_NOP   = 32'd0;
    localparam logic [31:0] OP_LDAR  = 32'd1;
    localparam logic [31:0] OP_LOAD  = 32'd2;
    localparam logic [31:0] OP_STORE = 32'd3;
    localparam logic [31:0] OP_ADD   = 32'd4;
    localparam logic [31:0] OP_MUL   = 32'd5;
    localparam logic [31:0] OP_INCAR = 32'd6;
    localparam logic [31:0] OP_JMP   = 32'd7;
    localparam logic [31:0] OP_JMPNZ = 32'd8;
    localparam logic [31:0] OP_END   = 32'd9;
    localparam logic [31:0] OP_FIRST_ILLEGAL = 32'd10;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_MUL  = 3'b010;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        LOADIR = 4'd2,
        DECODE = 4'd3,
        EXEC   = 4'd4,
        MEMRD  = 4'd5,
        MEMWR  = 4'd6,
        WB     = 4'd7,
        MULW   = 4'd8,
        HALT   = 4'd9
    } state_t;

    state_t                 state_reg;
    logic [OPCODE_W-1:0]    opcode_reg;
    logic [MUL_CNT_W-1:0]   mul_cnt_reg;
    logic                   illegal_reg;
    logic                   pc_clr_reg;
    logic [31:0]            op_num;
    logic [NCORES-1:0]      active_mask;
    logic                   mem_rd_next;
    logic                   mem_wr_next;
    logic                   unused_ir;

    assign op_num = 32'(opcode_reg);

    // Only the opcode field is decoded; the operand bits belong to the
    // datapath.
    assign unused_ir = ^IR;

`ifdef CORE_MASK_EN
    logic [NCORES-1:0] mask_reg;
    assign active_mask = mask_reg;
`else
    assign active_mask = {NCORES{1'b1}};
`endif

    // -----------------------------------------------------------------------
    // Sequencer: state, registered opcode, multiply counter, sticky illegal
    // flag, the one-cycle PC clear request and (optionally) the core mask.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            opcode_reg  <= '0;
            mul_cnt_reg <= '0;
            illegal_reg <= 1'b0;
            pc_clr_reg  <= 1'b0;
`ifdef CORE_MASK_EN
            mask_reg    <= '0;
`endif
        end else begin
            // pc_clr is a single-cycle request raised only on an accepted start.
            pc_clr_reg <= 1'b0;
            case (state_reg)
                IDLE, HALT: begin
                    if (start) begin
                        state_reg   <= FETCH;
                        pc_clr_reg  <= 1'b1;
                        illegal_reg <= 1'b0;
`ifdef CORE_MASK_EN
                        mask_reg    <= core_mask;
`endif
                    end
                end
                FETCH: begin
                    if (mem.mem_ack) begin
                        state_reg <= LOADIR;
                    end
                end
                LOADIR: begin
                    state_reg <= DECODE;
                end
                DECODE: begin
                    // IR was latched at the end of LOADIR and is stable here.
                    opcode_reg <= IR[IR_W-1 -: OPCODE_W];
                    state_reg  <= EXEC;
                end
                EXEC: begin
                    case (op_num)
                        OP_LOAD:  state_reg <= MEMRD;
                        OP_STORE: state_reg <= MEMWR;
                        OP_MUL: begin
                            state_reg   <= MULW;
                            mul_cnt_reg <= '0;
                        end
                        OP_END:   state_reg <= HALT;
                        default: begin
                            if (op_num >= OP_FIRST_ILLEGAL) begin
                                illegal_reg <= 1'b1;
                                state_reg   <= HALT;
                            end else begin
                                state_reg <= FETCH;
                            end
                        end
                    endcase
                end
                MEMRD: begin
                    if (mem.mem_ack) begin
                        state_reg <= WB;
                    end
                end
                WB: begin
                    state_reg <= FETCH;
                end
                MEMWR: begin
                    if (mem.mem_ack) begin
                        state_reg <= FETCH;
                    end
                end
                MULW: begin
                    if (mul_cnt_reg == MUL_LAST) begin
                        mul_cnt_reg <= '0;
                        state_reg   <= FETCH;
                    end else begin
                        mul_cnt_reg <= mul_cnt_reg + MUL_CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode. Because every term comes from a register cleared by the
    // asynchronous reset, the memory strobes drop as soon as rst_n falls.
    // -----------------------------------------------------------------------
    always_comb begin
        pc_clr      = pc_clr_reg;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        ir_load     = 1'b0;
        ar_load     = 1'b0;
        ar_inc      = 1'b0;
        mem_rd_next = 1'b0;
        mem_wr_next = 1'b0;
        alu_op      = ALU_PASS;
        acc_load    = 1'b0;
        busy        = (state_reg != IDLE) && (state_reg != HALT);
        done        = (state_reg == HALT);
        illegal     = illegal_reg;
        core_en     = busy ? active_mask : '0;

        case (state_reg)
            FETCH: begin
                mem_rd_next = 1'b1;
            end
            LOADIR: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
            end
            EXEC: begin
                case (op_num)
                    OP_LDAR:  ar_load = 1'b1;
                    OP_ADD: begin
                        alu_op   = ALU_ADD;
                        acc_load = 1'b1;
                    end
                    OP_INCAR: ar_inc  = 1'b1;
                    OP_JMP:   pc_load = 1'b1;
                    // Branch unless every participating core reports zero.
                    // Masked-out cores are forced to "zero", so an empty mask
                    // never branches.
                    OP_JMPNZ: pc_load = ~(&(z | ~active_mask));
                    default:  pc_load = 1'b0;
                endcase
            end
            MEMRD: begin
                mem_rd_next = 1'b1;
            end
            WB: begin
                alu_op   = ALU_PASS;
                acc_load = 1'b1;
            end
            MEMWR: begin
                mem_wr_next = 1'b1;
            end
            MULW: begin
                alu_op   = ALU_MUL;
                acc_load = (mul_cnt_reg == MUL_LAST);
            end
            default: begin
                pc_inc = 1'b0;
            end
        endcase
    end

    assign mem.mem_rd = mem_rd_next;
    assign mem.mem_wr = mem_wr_next;

endmodule

// File: tb/tb_multicore_controller.sv
// ---------------------------------------------------------------------------
// tb_multicore_controller
//   Directed, cycle-accurate bench for multicore_controller (NCORES=4,
//   MUL_LAT=3). Each cycle the stimulus pushes the expected output vector and
//   core enable onto a scoreboard queue; at the falling edge the entry is
//   popped and compared with what the controller drives.
//
//   Expected output vector bit layout:
//     [14] pc_clr  [13] pc_inc  [12] pc_load [11] ir_load [10] ar_load
//     [9]  ar_inc  [8]  mem_rd  [7]  mem_wr  [6:4] alu_op [3]  acc_load
//     [2]  busy    [1]  done    [0]  illegal
// ---------------------------------------------------------------------------
module tb_multicore_controller;

    localparam int IR_W    = 16;
    localparam int NCORES  = 4;
    localparam int MUL_LAT = 3;

    localparam logic [14:0] E_PCCLR  = 15'h4000;
    localparam logic [14:0] E_PCINC  = 15'h2000;
    localparam logic [14:0] E_PCLOAD = 15'h1000;
    localparam logic [14:0] E_IRLOAD = 15'h0800;
    localparam logic [14:0] E_ARLOAD = 15'h0400;
    localparam logic [14:0] E_ARINC  = 15'h0200;
    localparam logic [14:0] E_MEMRD  = 15'h0100;
    localparam logic [14:0] E_MEMWR  = 15'h0080;
    localparam logic [14:0] E_ALUADD = 15'h0010;
    localparam logic [14:0] E_ALUMUL = 15'h0020;
    localparam logic [14:0] E_ACC    = 15'h0008;
    localparam logic [14:0] E_BUSY   = 15'h0004;
    localparam logic [14:0] E_DONE   = 15'h0002;
    localparam logic [14:0] E_ILL    = 15'h0001;
    localparam logic [14:0] E_IDLE   = 15'h0000;

`ifdef CORE_MASK_EN
    localparam logic [NCORES-1:0] MASK = 4'b1011;
`else
    localparam logic [NCORES-1:0] MASK = 4'b1111;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [IR_W-1:0]   IR;
    logic [NCORES-1:0] z;
    logic              pc_clr, pc_inc, pc_load, ir_load, ar_load, ar_inc;
    logic [2:0]        alu_op;
    logic              acc_load;
    logic [NCORES-1:0] core_en;
    logic              busy, done, illegal;
    logic [14:0]       obs_vec;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string             tag;
        logic [14:0]       outs;
        logic [NCORES-1:0] en;
    } exp_t;

    exp_t sb[$];

    multicore_controller_if bus ();

`ifdef CORE_MASK_EN
    logic [NCORES-1:0] core_mask;
`endif

    multicore_controller #(
        .IR_W     (IR_W),
        .OPCODE_W (4),
        .NCORES   (NCORES),
        .MUL_LAT  (MUL_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .IR        (IR),
        .z         (z),
`ifdef CORE_MASK_EN
        .core_mask (core_mask),
`endif
        .mem       (bus),
        .pc_clr    (pc_clr),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .ir_load   (ir_load),
        .ar_load   (ar_load),
        .ar_inc    (ar_inc),
        .alu_op    (alu_op),
        .acc_load  (acc_load),
        .core_en   (core_en),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal)
    );

    assign obs_vec = {pc_clr, pc_inc, pc_load, ir_load, ar_load, ar_inc,
                      bus.mem_rd, bus.mem_wr, alu_op, acc_load, busy, done, illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare at the
    // falling edge, then advance to just after the next rising edge.
    task automatic cycle(input logic st, input logic ack, input logic [IR_W-1:0] ir,
                         input logic [NCORES-1:0] zz, input logic [14:0] exp_outs,
                         input string tag);
        exp_t e;
        logic [NCORES-1:0] exp_en;
        start       = st;
        bus.mem_ack = ack;
        IR          = ir;
        z           = zz;
        exp_en      = ((exp_outs & E_BUSY) != 15'h0) ? MASK : '0;
        sb.push_back('{tag: tag, outs: exp_outs, en: exp_en});
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, ".outs"}, 32'(obs_vec), 32'(e.outs));
        check({e.tag, ".core_en"}, 32'(core_en), 32'(e.en));
        $display("cycle %-10s outs=%h core_en=%b", e.tag, obs_vec, core_en);
        @(posedge clk);
        #1;
    endtask

    // FETCH (with nwait unacknowledged cycles), LOADIR, DECODE. mem_ack is
    // held high during LOADIR/DECODE to show it is ignored there.
    task automatic fetch_decode(input logic [IR_W-1:0] ir, input logic [NCORES-1:0] zz,
                                input int nwait, input logic first_clr);
        logic [14:0] f;
        f = E_MEMRD | E_BUSY | (first_clr ? E_PCCLR : E_IDLE);
        for (int i = 0; i < nwait; i++) begin
            cycle(1'b0, 1'b0, ir, zz, f, "fetch_wait");
            f = E_MEMRD | E_BUSY;
        end
        cycle(1'b0, 1'b1, ir, zz, f, "fetch");
        cycle(1'b0, 1'b1, ir, zz, E_IRLOAD | E_PCINC | E_BUSY, "loadir");
        cycle(1'b0, 1'b1, ir, zz, E_BUSY, "decode");
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        IR          = '0;
        z           = '0;
        bus.mem_ack = 1'b0;
`ifdef CORE_MASK_EN
        core_mask   = MASK;
`endif
        // Reset state
        @(negedge clk);
        check("reset.outs", 32'(obs_vec), 32'(E_IDLE));
        check("reset.core_en", 32'(core_en), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cycle(1'b0, 1'b1, 16'h0000, 4'hF, E_IDLE, "idle");
        cycle(1'b1, 1'b0, 16'h0000, 4'hF, E_IDLE, "idle_start");

        // NOP with two stalled fetch cycles; pc_clr only in the first
        fetch_decode(16'h0000, 4'hF, 2, 1'b1);
        cycle(1'b0, 1'b0, 16'h0000, 4'hF, E_BUSY, "exec_nop");

        // LOAD, memory ack delayed 3 cycles; start while busy is ignored
        fetch_decode(16'h2000, 4'hF, 0, 1'b0);
        cycle(1'b1, 1'b0, 16'h2000, 4'hF, E_BUSY, "exec_load");
        cycle(1'b0, 1'b0, 16'h2000, 4'hF, E_MEMRD | E_BUSY, "memrd_w1");
        cycle(1'b0, 1'b0, 16'h2000, 4'hF, E_MEMRD | E_BUSY, "memrd_w2");
        cycle(1'b0, 1'b0, 16'h2000, 4'hF, E_MEMRD | E_BUSY, "memrd_w3");
        cycle(1'b0, 1'b1, 16'h2000, 4'hF, E_MEMRD | E_BUSY, "memrd_ack");
        cycle(1'b0, 1'b1, 16'h2000, 4'hF, E_ACC | E_BUSY, "wb");

        // STORE with one wait cycle
        fetch_decode(16'h3000, 4'hF, 0, 1'b0);
        cycle(1'b0, 1'b0, 16'h3000, 4'hF, E_BUSY, "exec_store");
        cycle(1'b0, 1'b0, 16'h3000, 4'hF, E_MEMWR | E_BUSY, "memwr_w1");
        cycle(1'b0, 1'b1, 16'h3000, 4'hF, E_MEMWR | E_BUSY, "memwr_ack");

        // Single-cycle execute opcodes
        fetch_decode(16'h4000, 4'hF, 0, 1'b0);
        cycle(1'b0, 1'b0, 16'h4000, 4'hF, E_ALUADD | E_ACC | E_BUSY, "exec_add");
        fetch_decode(16'h1000, 4'hF, 0, 1'b0);
        cycle(1'b0, 1'b0, 16'h1000, 4'hF, E_ARLOAD | E_BUSY, "exec_ldar");
        fetch_decode(16'h6000, 4'hF, 0, 1'b0);
        cycle(1'b0, 1'b0, 16'h6000, 4'hF, E_ARINC | E_BUSY, "exec_incar");
        fetch_decode(16'h7000, 4'hF, 0, 1'b0);
        cycle(1'b0, 1'b0, 16'h7000, 4'hF, E_PCLOAD | E_BUSY, "exec_jmp");

        // MUL: alu_op=010 for MUL_LAT cycles, acc_load only in the last
        fetch_decode(16'h5000, 4'hF, 0, 1'b0);
        cycle(1'b0, 1'b0, 16'h5000, 4'hF, E_BUSY, "exec_mul");
        cycle(1'b0, 1'b0, 16'h5000, 4'hF, E_ALUMUL | E_BUSY, "mulw1");
        cycle(1'b0, 1'b0, 16'h5000, 4'hF, E_ALUMUL | E_BUSY, "mulw2");
        cycle(1'b0, 1'b0, 16'h5000, 4'hF, E_ALUMUL | E_ACC | E_BUSY, "mulw3");

        // JMPNZ: all zero -> not taken; core 2 nonzero -> taken unless masked
        fetch_decode(16'h8000, 4'hF, 0, 1'b0);
        cycle(1'b0, 1'b0, 16'h8000, 4'b1111, E_BUSY, "jmpnz_1111");
        fetch_decode(16'h8000, 4'hF, 0, 1'b0);
`ifdef CORE_MASK_EN
        cycle(1'b0, 1'b0, 16'h8000, 4'b1011, E_BUSY, "jmpnz_1011");
`else
        cycle(1'b0, 1'b0, 16'h8000, 4'b1011, E_PCLOAD | E_BUSY, "jmpnz_1011");
`endif

        // END -> HALT, then restart
        fetch_decode(16'h9000, 4'hF, 0, 1'b0);
        cycle(1'b0, 1'b0, 16'h9000, 4'hF, E_BUSY, "exec_end");
        cycle(1'b0, 1'b1, 16'h9000, 4'hF, E_DONE, "halt");
        cycle(1'b1, 1'b0, 16'h9000, 4'hF, E_DONE, "halt_start");

        // Illegal opcode: sticky until the next accepted start
        fetch_decode(16'hF000, 4'hF, 0, 1'b1);
        cycle(1'b0, 1'b0, 16'hF000, 4'hF, E_BUSY, "exec_ill");
        cycle(1'b0, 1'b0, 16'hF000, 4'hF, E_DONE | E_ILL, "halt_ill");
        cycle(1'b1, 1'b0, 16'hF000, 4'hF, E_DONE | E_ILL, "ill_start");

        // STORE again; reset asserted in the middle of the MEMWR wait
        fetch_decode(16'h3000, 4'hF, 0, 1'b1);
        cycle(1'b0, 1'b0, 16'h3000, 4'hF, E_BUSY, "exec_store2");
        bus.mem_ack = 1'b0;
        #2;
        check("memwr_before_rst", 32'(bus.mem_wr), 32'h1);
        rst_n = 1'b0;
        #1;
        check("memwr_async_drop", 32'(bus.mem_wr), 32'h0);
        check("rst_mid.outs", 32'(obs_vec), 32'(E_IDLE));
        check("rst_mid.core_en", 32'(core_en), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 16'h3000, 4'hF, E_IDLE, "idle_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
